rate_limiter_scheduler: RTL and testbench

RATE_LIMITER_SCHEDULER -- requirements
Module: rate_limiter_scheduler

---
 rtl/rate_limiter_scheduler_if.sv | 10 +
 rtl/rate_limiter_scheduler.sv | 100 ++++++++++
 tb/tb_rate_limiter_scheduler.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/rate_limiter_scheduler_if.sv
// Packet handshake between a packet source (master) and the rate-limited scheduler (slave).
interface rate_limiter_scheduler_if;
    logic        pkt_rdy;
    logic [15:0] pkt_len;
    logic        pkt_done;
    logic        pkt_go;

    modport master (output pkt_rdy, output pkt_len, output pkt_done, input pkt_go);
    modport slave  (input pkt_rdy, input pkt_len, input pkt_done, output pkt_go);
endinterface

// File: rtl/rate_limiter_scheduler.sv
// Token-bucket rate limiter: periodic refill, per-packet byte charge, single-pulse grant.
module rate_limiter_scheduler #(
    parameter int TOKEN_WIDTH    = 24,
    parameter int BUCKET_DEPTH   = 16384,
    parameter int OVERHEAD_BYTES = 24
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [19:0]            token_interval,
    input  logic [7:0]             token_increment,
    input  logic                   enable_rate_limit,
    input  logic                   include_overhead,
    rate_limiter_scheduler_if.slave pkt,
    output logic [TOKEN_WIDTH-1:0] tokens,
    output logic [31:0]            stall_cnt
);

    // Arithmetic width wide enough for both the token level and a 17-bit cost, plus a carry.
    localparam int AW = ((TOKEN_WIDTH > 17) ? TOKEN_WIDTH : 17) + 1;
    localparam logic [AW-1:0] DEPTH_A = AW'(BUCKET_DEPTH);

    typedef enum logic [1:0] {IDLE, ELIGIBLE, SEND} state_t;

    state_t                 state_q;
    logic [19:0]            cnt_q;
    logic [TOKEN_WIDTH-1:0] tokens_q, tokens_d;
    logic [16:0]            cost_q, cost_d;
    logic [31:0]            stall_q;
    logic                   pkt_go_q;

    logic [19:0]   ivl_m1;
    logic          wrap;
    logic          grant;
    logic [AW-1:0] tok_ext, cost_ext, refilled, charge;

    function automatic logic [AW-1:0] sat_refill(input logic [AW-1:0] t, input logic [7:0] inc);
        logic [AW-1:0] s;
        s = t + AW'(inc);
        return (s > DEPTH_A) ? DEPTH_A : s;
    endfunction

    function automatic logic [AW-1:0] min_val(input logic [AW-1:0] a, input logic [AW-1:0] b);
        return (a < b) ? a : b;
    endfunction

    always_comb begin
        // A zero interval behaves as 1; comparing with >= makes a shrunk interval wrap at once.
        ivl_m1   = (token_interval == 20'd0) ? 20'd0 : token_interval - 20'd1;
        wrap     = (cnt_q >= ivl_m1);
        tok_ext  = AW'(tokens_q);
        cost_ext = AW'(cost_q);
        refilled = wrap ? sat_refill(tok_ext, token_increment) : tok_ext;
        grant    = (state_q == ELIGIBLE) &&
                   (!enable_rate_limit || (tok_ext >= cost_ext) ||
                    ((cost_ext > DEPTH_A) && (tok_ext == DEPTH_A)));
        charge   = (grant && enable_rate_limit) ? min_val(cost_ext, refilled) : '0;
        tokens_d = TOKEN_WIDTH'(refilled - charge);
        cost_d   = {1'b0, pkt.pkt_len} + (include_overhead ? 17'(OVERHEAD_BYTES) : 17'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            tokens_q <= '0;
            cost_q   <= '0;
            stall_q  <= '0;
            pkt_go_q <= 1'b0;
        end else begin
            cnt_q    <= wrap ? 20'd0 : cnt_q + 20'd1;
            tokens_q <= tokens_d;
            pkt_go_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pkt.pkt_rdy) begin
                        state_q <= ELIGIBLE;
                        cost_q  <= cost_d;
                    end
                end
                ELIGIBLE: begin
                    if (grant) begin
                        state_q  <= SEND;
                        pkt_go_q <= 1'b1;
                    end else begin
                        stall_q <= stall_q + 32'd1;
                    end
                end
                SEND: begin
                    if (pkt.pkt_done) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pkt.pkt_go = pkt_go_q;
    assign tokens     = tokens_q;
    assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_rate_limiter_scheduler.sv
// Directed-vector bench for rate_limiter_scheduler with hand-computed expectations.
module tb_rate_limiter_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] token_interval;
    logic [7:0]  token_increment;
    logic        enable_rate_limit;
    logic        include_overhead;
    logic [23:0] tokens;
    logic [31:0] stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    rate_limiter_scheduler_if pif();

    rate_limiter_scheduler #(
        .TOKEN_WIDTH(24), .BUCKET_DEPTH(16384), .OVERHEAD_BYTES(24)
    ) dut (
        .clk(clk),
        .reset(reset),
        .token_interval(token_interval),
        .token_increment(token_increment),
        .enable_rate_limit(enable_rate_limit),
        .include_overhead(include_overhead),
        .pkt(pif.slave),
        .tokens(tokens),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [19:0] ivl, input logic [7:0] inc, input logic en,
                       input logic ovh, input logic [15:0] len);
        token_interval    = ivl;
        token_increment   = inc;
        enable_rate_limit = en;
        include_overhead  = ovh;
        pif.pkt_len       = len;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        pif.pkt_rdy  = 1'b0;
        pif.pkt_done = 1'b0;
        tick(2);
    endtask

    task automatic finish_pkt();
        pif.pkt_rdy  = 1'b0;
        pif.pkt_done = 1'b1;
        tick(1);
        pif.pkt_done = 1'b0;
    endtask

    initial begin
        cfg(20'd4, 8'd10, 1'b1, 1'b0, 16'd60);
        reset = 1'b1; pif.pkt_rdy = 1'b0; pif.pkt_done = 1'b0;

        // Basic refill and charge; a pkt_done while ELIGIBLE must be ignored.
        do_reset();
        chk("rst_tokens", 32'(tokens), 0);
        chk("rst_stall", stall_cnt, 0);
        chk("rst_go", 32'(pif.pkt_go), 0);
        reset = 1'b0; pif.pkt_rdy = 1'b1;
        tick(9);
        pif.pkt_done = 1'b1;
        tick(1);
        pif.pkt_done = 1'b0;
        tick(14);
        chk("refill_tok60", 32'(tokens), 60);
        chk("refill_nogo", 32'(pif.pkt_go), 0);
        tick(1);
        chk("refill_go", 32'(pif.pkt_go), 1);
        chk("refill_charged", 32'(tokens), 0);
        chk("refill_stall", stall_cnt, 23);
        finish_pkt();
        chk("refill_go_once", 32'(pif.pkt_go), 0);
        tick(3);
        chk("idle_stall_hold", stall_cnt, 23);
        chk("idle_refill", 32'(tokens), 10);

        // Overhead, with pkt_len/overhead changed after the cost is latched.
        do_reset();
        cfg(20'd4, 8'd10, 1'b1, 1'b1, 16'd60);
        reset = 1'b0; pif.pkt_rdy = 1'b1;
        tick(1);
        pif.pkt_len = 16'd5; include_overhead = 1'b0;
        tick(35);
        chk("ovh_tok90", 32'(tokens), 90);
        chk("ovh_nogo", 32'(pif.pkt_go), 0);
        tick(1);
        chk("ovh_go", 32'(pif.pkt_go), 1);
        chk("ovh_tokens", 32'(tokens), 6);
        chk("ovh_stall", stall_cnt, 35);
        finish_pkt();

        // Rate limiting disabled: 2-cycle grant, no charge, refills continue.
        do_reset();
        cfg(20'd4, 8'd10, 1'b0, 1'b0, 16'd60);
        reset = 1'b0; pif.pkt_rdy = 1'b1;
        tick(1);
        chk("dis_nogo", 32'(pif.pkt_go), 0);
        tick(1);
        chk("dis_go", 32'(pif.pkt_go), 1);
        chk("dis_tokens", 32'(tokens), 0);
        chk("dis_stall", stall_cnt, 0);
        finish_pkt();
        tick(1);
        chk("dis_refill", 32'(tokens), 10);

        // Enable dropping while ELIGIBLE grants on the next edge without charge.
        do_reset();
        cfg(20'd4, 8'd10, 1'b1, 1'b0, 16'd60);
        reset = 1'b0; pif.pkt_rdy = 1'b1;
        tick(5);
        chk("endrop_tok", 32'(tokens), 10);
        chk("endrop_nogo", 32'(pif.pkt_go), 0);
        enable_rate_limit = 1'b0;
        tick(1);
        chk("endrop_go", 32'(pif.pkt_go), 1);
        chk("endrop_tokens", 32'(tokens), 10);
        chk("endrop_stall", stall_cnt, 4);
        finish_pkt();

        // Saturation and oversize packet.
        do_reset();
        cfg(20'd1, 8'd255, 1'b1, 1'b0, 16'd20000);
        reset = 1'b0;
        tick(64);
        chk("sat_16320", 32'(tokens), 16320);
        tick(6);
        chk("sat_pinned", 32'(tokens), 16384);
        pif.pkt_rdy = 1'b1;
        tick(1);
        chk("ovs_nogo", 32'(pif.pkt_go), 0);
        chk("ovs_full", 32'(tokens), 16384);
        tick(1);
        chk("ovs_go", 32'(pif.pkt_go), 1);
        chk("ovs_drained", 32'(tokens), 0);
        finish_pkt();
        chk("ovs_refill", 32'(tokens), 255);

        // Interval 0 refills every cycle.
        do_reset();
        cfg(20'd0, 8'd3, 1'b1, 1'b0, 16'd60);
        reset = 1'b0;
        tick(1);
        chk("ivl0_1", 32'(tokens), 3);
        tick(1);
        chk("ivl0_2", 32'(tokens), 6);

        // Interval shrunk from 1000 to 2 at count 500.
        do_reset();
        cfg(20'd1000, 8'd1, 1'b1, 1'b0, 16'd60);
        reset = 1'b0;
        tick(500);
        chk("shrink_pre", 32'(tokens), 0);
        token_interval = 20'd2;
        tick(1);
        chk("shrink_wrap", 32'(tokens), 1);
        tick(1);
        chk("shrink_hold", 32'(tokens), 1);
        tick(1);
        chk("shrink_p2a", 32'(tokens), 2);
        tick(2);
        chk("shrink_p2b", 32'(tokens), 3);

        // Reset mid-SEND, then pkt_done in IDLE is ignored.
        do_reset();
        cfg(20'd4, 8'd10, 1'b0, 1'b0, 16'd60);
        reset = 1'b0; pif.pkt_rdy = 1'b1;
        tick(2);
        chk("rsend_go", 32'(pif.pkt_go), 1);
        reset = 1'b1; pif.pkt_rdy = 1'b0;
        tick(1);
        chk("rsend_go_clr", 32'(pif.pkt_go), 0);
        chk("rsend_tokens", 32'(tokens), 0);
        reset = 1'b0; pif.pkt_done = 1'b1;
        tick(1);
        pif.pkt_done = 1'b0;
        chk("rsend_done_go", 32'(pif.pkt_go), 0);
        tick(1);
        chk("rsend_idle_go", 32'(pif.pkt_go), 0);
        pif.pkt_rdy = 1'b1;
        tick(1);
        chk("rsend_new_nogo", 32'(pif.pkt_go), 0);
        tick(1);
        chk("rsend_new_go", 32'(pif.pkt_go), 1);
        finish_pkt();

        // Reset mid-ELIGIBLE with pkt_rdy held: refill suppressed, packet restarts.
        do_reset();
        cfg(20'd4, 8'd10, 1'b1, 1'b0, 16'd60);
        reset = 1'b0; pif.pkt_rdy = 1'b1;
        tick(3);
        chk("relig_stall", stall_cnt, 2);
        reset = 1'b1;
        tick(1);
        chk("relig_stall_clr", stall_cnt, 0);
        chk("relig_no_refill", 32'(tokens), 0);
        reset = 1'b0;
        tick(24);
        chk("relig_nogo", 32'(pif.pkt_go), 0);
        chk("relig_tok60", 32'(tokens), 60);
        tick(1);
        chk("relig_go", 32'(pif.pkt_go), 1);
        chk("relig_stall2", stall_cnt, 23);
        finish_pkt();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
